bc_io_interrupt: RTL and testbench
==================================

# bc_io_interrupt

Input/output and interrupt unit for the basic computer. It holds the INPR/OUTR character registers, the FGI/FGO device flags, and the IEN/R interrupt flip-flops, and executes the six I/O instructions on request from the controller. It also sequences the three-cycle interrupt micro-program (RT0–RT2) in place of instruction fetch. It sits directly upstream of the controller, which consumes its R, skip and micro-op strobes.

## Interface
- WIDTH, 16: instruction/AC width.
- IO_WIDTH, 8: character width of INPR/OUTR.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- IR  in  WIDTH  current instruction register.
- io_exec  in  1  one-cycle strobe from the controller: T3 with D7 and I=1 (I/O instruction).
- fetch_busy  in  1  controller is in T0, T1 or T2.
- sc_t0  in  1  controller sequence counter is at T0.
- AC_LO  in  IO_WIDTH  AC[IO_WIDTH-1:0].
- in_data  in  IO_WIDTH; in_valid  in  1; in_ready  out  1: input device handshake.
- out_data  out  IO_WIDTH (=OUTR); out_valid  out  1; out_ready  in  1: output device handshake.
- INPR  out  IO_WIDTH  input character, driven to the AC low byte.
- ac_ld_inpr  out  1  AC[7:0] <- INPR request.
- skip  out  1  PC <- PC+1 request.
- FGI, FGO, IEN, R  out  1 each  flag state.
- int_busy  out  1  interrupt cycle in progress (RT0–RT2); the controller suppresses fetch.
- int_ar_clr, int_tr_ld_pc, int_mem_wr_tr, int_pc_clr, int_pc_inr, int_done  out  1 each  interrupt micro-op strobes.

## Operation
- Reset values: INPR=0, OUTR=0, FGI=0, FGO=1, IEN=0, R=0, state IDLE, all strobes and skip 0.
- I/O decode applies only when io_exec=1. Bits are checked highest first, and only the first set bit acts:
  - IR[11] INP: ac_ld_inpr=1, FGI<=0.
  - IR[10] OUT: OUTR<=AC_LO, FGO<=0.
  - IR[9] SKI: skip=FGI.
  - IR[8] SKO: skip=FGO.
  - IR[7] ION: IEN<=1.
  - IR[6] IOF: IEN<=0.
  - No bit set: no action.
- Input handshake:
  - in_ready = ~FGI & ~(io_exec & IR[11]).
  - When in_valid & in_ready: INPR<=in_data, FGI<=1.
  - INP with FGI=0 still pulses ac_ld_inpr (stale INPR); FGI stays 0.
- Output handshake:
  - out_valid = ~FGO.
  - When out_valid & out_ready: FGO<=1.
  - OUT with FGO=0 overwrites OUTR; out_valid stays 1.
- Interrupt FSM (Moore, state registered; strobes decoded from state):
  - IDLE: if IEN & (FGI|FGO) & ~fetch_busy, then R<=1 and go to PEND.
  - PEND: wait until sc_t0=1, then go to RT0. IOF executed while in PEND does not cancel the interrupt; R stays 1.
  - RT0: int_ar_clr, int_tr_ld_pc (AR<-0, TR<-PC); go to RT1.
  - RT1: int_mem_wr_tr, int_pc_clr (M[AR]<-TR, PC<-0); go to RT2.
  - RT2: int_pc_inr, int_done (PC<-PC+1, SC<-0); IEN<=0, R<=0; go to IDLE.
- int_busy=1 in RT0, RT1 and RT2.
- io_exec during RT0–RT2 is a controller fault and is ignored.

## Timing
- skip and ac_ld_inpr are combinational in the io_exec cycle (0 latency).
- Register and flag updates take effect on the same clock edge.
- R is visible 1 cycle after its set condition.
- Interrupt cycle: exactly 3 cycles from the sc_t0 edge. R and IEN read 0 in the cycle after RT2.
- Simultaneous events:
  - INP while in_valid=1: the device is stalled that cycle; no lost character.
  - OUT while out_ready=1 and FGO=0: the handshake completes (FGO<=1), then OUT wins, so FGO=0 and OUTR holds the new AC_LO.
  - ION and flag arrival in the same cycle: R can set at the earliest the next cycle.
- rst asserted mid-interrupt: all state returns to reset values on that edge; strobes read 0 the next cycle.

## Configuration
- BC_INTERRUPT_EN defined: the interrupt FSM, R, int_busy and int_* strobes operate as specified.
- BC_INTERRUPT_EN undefined:
  - The FSM is not built; R, int_busy and all int_* strobes are tied to 0.
  - ION/IOF still update IEN.
  - I/O instructions and handshakes are unchanged.

## Test plan
- Reset: assert rst one cycle -> FGO=1, FGI=0, IEN=0, R=0, out_valid=0, in_ready=1, all strobes 0.
- Input: in_data=8'h41 with in_valid for one cycle -> FGI=1, INPR=8'h41, in_ready=0; SKI io_exec (IR=16'hF200) -> skip=1; INP (IR=16'hF800) -> ac_ld_inpr=1, then FGI=0.
- Output: AC_LO=8'h5A, OUT (IR=16'hF400) -> out_data=8'h5A, out_valid=1, SKO skip=0; out_ready one cycle -> FGO=1, SKO skip=1.
- Interrupt: ION (IR=16'hF080) with FGO=1 and fetch_busy=0 -> R=1; pulse sc_t0 -> strobes RT0, RT1, RT2 on 3 consecutive cycles, int_busy=1 throughout; then IEN=0, R=0.
- Collision: FGI=0, INP io_exec while in_valid=1 -> in_ready=0 that cycle; the character is accepted the next cycle (FGI=1).
- Reset in RT1 -> next cycle state IDLE, int_busy=0, IEN=0, R=0.

Source files
------------

// File: rtl/bc_io_interrupt.sv
// Basic-computer I/O unit: INPR/OUTR, FGI/FGO, IEN/R and the RT0-RT2 interrupt sequencer.
// The interrupt FSM is built only when BC_INTERRUPT_EN is defined; otherwise R, int_busy and int_* read 0.
module bc_io_interrupt #(
   parameter int WIDTH    = 16,
   parameter int IO_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    IR,
   input  logic                io_exec,
   input  logic                fetch_busy,
   input  logic                sc_t0,
   input  logic [IO_WIDTH-1:0] AC_LO,
   input  logic [IO_WIDTH-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [IO_WIDTH-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [IO_WIDTH-1:0] INPR,
   output logic                ac_ld_inpr,
   output logic                skip,
   output logic                FGI,
   output logic                FGO,
   output logic                IEN,
   output logic                R,
   output logic                int_busy,
   output logic                int_ar_clr,
   output logic                int_tr_ld_pc,
   output logic                int_mem_wr_tr,
   output logic                int_pc_clr,
   output logic                int_pc_inr,
   output logic                int_done
);

   logic                io_act;
   logic                do_inp, do_out, do_ski, do_sko, do_ion, do_iof;
   logic                in_fire, out_fire;
   logic [IO_WIDTH-1:0] outr;

   // An io_exec during the interrupt cycle is a controller fault and is dropped.
   assign io_act = io_exec & ~int_busy;

   always_comb begin
      do_inp = 1'b0;
      do_out = 1'b0;
      do_ski = 1'b0;
      do_sko = 1'b0;
      do_ion = 1'b0;
      do_iof = 1'b0;
      if (io_act) begin
         if (IR[11])      do_inp = 1'b1;
         else if (IR[10]) do_out = 1'b1;
         else if (IR[9])  do_ski = 1'b1;
         else if (IR[8])  do_sko = 1'b1;
         else if (IR[7])  do_ion = 1'b1;
         else if (IR[6])  do_iof = 1'b1;
      end
   end

   assign ac_ld_inpr = do_inp;
   assign skip       = (do_ski & FGI) | (do_sko & FGO);
   assign in_ready   = ~FGI & ~do_inp;
   assign in_fire    = in_valid & in_ready;
   assign out_valid  = ~FGO;
   assign out_fire   = out_valid & out_ready;
   assign out_data   = outr;

   always_ff @(posedge clk) begin
      if (rst) begin
         INPR <= '0;
         outr <= '0;
         FGI  <= 1'b0;
         FGO  <= 1'b1;
         IEN  <= 1'b0;
      end else begin
         if (in_fire) begin
            INPR <= in_data;
            FGI  <= 1'b1;
         end
         if (do_inp) FGI <= 1'b0;
         // OUT is applied after a completing handshake so the new character wins.
         if (out_fire) FGO <= 1'b1;
         if (do_out) begin
            outr <= AC_LO;
            FGO  <= 1'b0;
         end
         if (do_ion) IEN <= 1'b1;
         if (do_iof | int_done) IEN <= 1'b0;
      end
   end

   logic unused_ir;
   assign unused_ir = ^{IR[WIDTH-1:12], IR[5:0]};

`ifdef BC_INTERRUPT_EN
   typedef enum logic [2:0] {S_IDLE, S_PEND, S_RT0, S_RT1, S_RT2} state_t;

   state_t state, state_nxt;
   logic   r_set;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         R     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (r_set)              R <= 1'b1;
         else if (state == S_RT2) R <= 1'b0;
      end
   end

   always_comb begin
      state_nxt     = state;
      r_set         = 1'b0;
      int_busy      = 1'b0;
      int_ar_clr    = 1'b0;
      int_tr_ld_pc  = 1'b0;
      int_mem_wr_tr = 1'b0;
      int_pc_clr    = 1'b0;
      int_pc_inr    = 1'b0;
      int_done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (IEN & (FGI | FGO) & ~fetch_busy) begin
               r_set     = 1'b1;
               state_nxt = S_PEND;
            end
         end
         // IOF here does not cancel: the request is already committed.
         S_PEND: if (sc_t0) state_nxt = S_RT0;
         S_RT0: begin
            int_busy     = 1'b1;
            int_ar_clr   = 1'b1;
            int_tr_ld_pc = 1'b1;
            state_nxt    = S_RT1;
         end
         S_RT1: begin
            int_busy      = 1'b1;
            int_mem_wr_tr = 1'b1;
            int_pc_clr    = 1'b1;
            state_nxt     = S_RT2;
         end
         S_RT2: begin
            int_busy   = 1'b1;
            int_pc_inr = 1'b1;
            int_done   = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end
`else
   assign R             = 1'b0;
   assign int_busy      = 1'b0;
   assign int_ar_clr    = 1'b0;
   assign int_tr_ld_pc  = 1'b0;
   assign int_mem_wr_tr = 1'b0;
   assign int_pc_clr    = 1'b0;
   assign int_pc_inr    = 1'b0;
   assign int_done      = 1'b0;

   logic unused_ctl;
   assign unused_ctl = fetch_busy ^ sc_t0;
`endif

endmodule

// File: tb/tb_bc_io_interrupt.sv
// Scoreboard bench for bc_io_interrupt; expectations follow BC_INTERRUPT_EN if it is defined.
module tb_bc_io_interrupt;
   localparam int WIDTH    = 16;
   localparam int IO_WIDTH = 8;
`ifdef BC_INTERRUPT_EN
   localparam bit IE = 1'b1;
`else
   localparam bit IE = 1'b0;
`endif
   localparam logic [5:0] RT0 = 6'b110000;
   localparam logic [5:0] RT1 = 6'b001100;
   localparam logic [5:0] RT2 = 6'b000011;

   logic clk = 1'b0;
   logic rst;
   logic [WIDTH-1:0] IR;
   logic io_exec, fetch_busy, sc_t0, in_valid, out_ready;
   logic [IO_WIDTH-1:0] AC_LO, in_data;
   logic in_ready, out_valid, ac_ld_inpr, skip, FGI, FGO, IEN, R, int_busy;
   logic int_ar_clr, int_tr_ld_pc, int_mem_wr_tr, int_pc_clr, int_pc_inr, int_done;
   logic [IO_WIDTH-1:0] out_data, INPR;

   always #5 clk = ~clk;

   bc_io_interrupt #(.WIDTH(WIDTH), .IO_WIDTH(IO_WIDTH)) dut (
      .clk(clk), .rst(rst), .IR(IR), .io_exec(io_exec), .fetch_busy(fetch_busy),
      .sc_t0(sc_t0), .AC_LO(AC_LO), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .INPR(INPR), .ac_ld_inpr(ac_ld_inpr), .skip(skip),
      .FGI(FGI), .FGO(FGO), .IEN(IEN), .R(R), .int_busy(int_busy),
      .int_ar_clr(int_ar_clr), .int_tr_ld_pc(int_tr_ld_pc),
      .int_mem_wr_tr(int_mem_wr_tr), .int_pc_clr(int_pc_clr),
      .int_pc_inr(int_pc_inr), .int_done(int_done)
   );

   wire [14:0] flags = {FGI, FGO, IEN, R, in_ready, out_valid, skip, ac_ld_inpr, int_busy,
                        int_ar_clr, int_tr_ld_pc, int_mem_wr_tr, int_pc_clr, int_pc_inr, int_done};

   int total = 0;
   int bad   = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_v, obs;

   function automatic logic [14:0] f(input bit fgi, fgo, ien, r, inr, ov, sk, ld, busy,
                                     input logic [5:0] st);
      return {fgi, fgo, ien, r, inr, ov, sk, ld, busy, st};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; IR = '0; io_exec = 0; fetch_busy = 0; sc_t0 = 0;
      AC_LO = '0; in_data = '0; in_valid = 0; out_ready = 0;
      tick();
      rst = 1'b0;
      sb.push_back(32'(f(0,1,0,0,1,0,0,0,0,6'b0)));
      sb.push_back(32'h0);
      sb.push_back(32'h0);
      #1;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset_flags got=%h want=%h", obs, exp_v); end
      obs = 32'(INPR); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset_inpr got=%h want=%h", obs, exp_v); end
      obs = 32'(out_data); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset_outr got=%h want=%h", obs, exp_v); end
   endtask

   task automatic test_input();
      in_data = 8'h41; in_valid = 1;
      sb.push_back(32'(f(1,1,0,0,0,0,0,0,0,6'b0)));
      sb.push_back(32'h41);
      tick();
      in_valid = 0;
      #1;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL input_flags got=%h want=%h", obs, exp_v); end
      obs = 32'(INPR); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL input_inpr got=%h want=%h", obs, exp_v); end
      io_exec = 1; IR = 16'hF200;
      sb.push_back(32'(f(1,1,0,0,0,0,1,0,0,6'b0)));
      #1;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL ski_skip got=%h want=%h", obs, exp_v); end
      tick();
      IR = 16'hF800;
      sb.push_back(32'(f(1,1,0,0,0,0,0,1,0,6'b0)));
      #1;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL inp_ld got=%h want=%h", obs, exp_v); end
      tick();
      io_exec = 0;
      sb.push_back(32'(f(0,1,0,0,1,0,0,0,0,6'b0)));
      #1;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL inp_clr_fgi got=%h want=%h", obs, exp_v); end
   endtask

   task automatic test_output();
      AC_LO = 8'h5A; io_exec = 1; IR = 16'hF400;
      sb.push_back(32'h5A);
      sb.push_back(32'(f(0,0,0,0,1,1,0,0,0,6'b0)));
      tick();
      IR = 16'hF100;
      #1;
      obs = 32'(out_data); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL out_data got=%h want=%h", obs, exp_v); end
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL sko_busy got=%h want=%h", obs, exp_v); end
      tick();
      io_exec = 0; out_ready = 1;
      tick();
      out_ready = 0; io_exec = 1; IR = 16'hF100;
      sb.push_back(32'(f(0,1,0,0,1,0,1,0,0,6'b0)));
      #1;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL sko_done got=%h want=%h", obs, exp_v); end
      tick();
      io_exec = 0;
   endtask

   task automatic test_out_collision();
      AC_LO = 8'h11; io_exec = 1; IR = 16'hF400;
      tick();
      AC_LO = 8'h22; out_ready = 1;
      sb.push_back(32'h22);
      sb.push_back(32'(f(0,0,0,0,1,1,0,0,0,6'b0)));
      tick();
      io_exec = 0; out_ready = 0;
      #1;
      obs = 32'(out_data); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL outcol_data got=%h want=%h", obs, exp_v); end
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL outcol_fgo got=%h want=%h", obs, exp_v); end
      out_ready = 1;
      tick();
      out_ready = 0;
   endtask

   task automatic test_in_collision();
      io_exec = 1; IR = 16'hF800; in_valid = 1; in_data = 8'h77;
      sb.push_back(32'(f(0,1,0,0,0,0,0,1,0,6'b0)));
      #1;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL incol_stall got=%h want=%h", obs, exp_v); end
      tick();
      io_exec = 0;
      sb.push_back(32'(f(0,1,0,0,1,0,0,0,0,6'b0)));
      sb.push_back(32'h41);
      #1;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL incol_ready got=%h want=%h", obs, exp_v); end
      obs = 32'(INPR); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL incol_hold got=%h want=%h", obs, exp_v); end
      sb.push_back(32'(f(1,1,0,0,0,0,0,0,0,6'b0)));
      sb.push_back(32'h77);
      tick();
      in_valid = 0;
      #1;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL incol_accept got=%h want=%h", obs, exp_v); end
      obs = 32'(INPR); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL incol_inpr got=%h want=%h", obs, exp_v); end
      io_exec = 1; IR = 16'hF800;
      tick();
      io_exec = 0;
   endtask

   task automatic test_interrupt();
      fetch_busy = 1; io_exec = 1; IR = 16'hF080;
      sb.push_back(32'(f(0,1,1,0,1,0,0,0,0,6'b0)));
      sb.push_back(32'(f(0,1,1,0,1,0,0,0,0,6'b0)));
      tick();
      io_exec = 0;
      #1;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL ion_set got=%h want=%h", obs, exp_v); end
      tick();
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL fetch_block got=%h want=%h", obs, exp_v); end
      fetch_busy = 0;
      sb.push_back(32'(f(0,1,1,IE,1,0,0,0,0,6'b0)));
      sb.push_back(32'(f(0,1,1,IE,1,0,0,0,0,6'b0)));
      tick();
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL r_set got=%h want=%h", obs, exp_v); end
      tick();
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL pend_wait got=%h want=%h", obs, exp_v); end
      sc_t0 = 1;
      sb.push_back(32'(f(0,1,1,IE,1,0,0,0,IE,RT0 & {6{IE}})));
      sb.push_back(32'(f(0,1,IE,IE,1,0,0,0,IE,RT1 & {6{IE}})));
      sb.push_back(32'(f(0,1,IE,IE,1,0,0,0,IE,RT2 & {6{IE}})));
      sb.push_back(32'(f(0,1,0,0,1,0,0,0,0,6'b0)));
      tick();
      sc_t0 = 0;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rt0 got=%h want=%h", obs, exp_v); end
      io_exec = 1; IR = 16'hF040;
      tick();
      io_exec = 0;
      #1;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rt1 got=%h want=%h", obs, exp_v); end
      tick();
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rt2 got=%h want=%h", obs, exp_v); end
      tick();
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL int_end got=%h want=%h", obs, exp_v); end
   endtask

   task automatic test_reset_mid();
      io_exec = 1; IR = 16'hF080;
      tick();
      io_exec = 0;
      tick();
      io_exec = 1; IR = 16'hF040; sc_t0 = 1;
      sb.push_back(32'(f(0,1,0,IE,1,0,0,0,IE,RT0 & {6{IE}})));
      sb.push_back(32'(f(0,1,0,IE,1,0,0,0,IE,RT1 & {6{IE}})));
      tick();
      io_exec = 0; sc_t0 = 0;
      #1;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL iof_pend got=%h want=%h", obs, exp_v); end
      tick();
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL mid_rt1 got=%h want=%h", obs, exp_v); end
      rst = 1;
      sb.push_back(32'(f(0,1,0,0,1,0,0,0,0,6'b0)));
      sb.push_back(32'h0);
      tick();
      rst = 0;
      #1;
      obs = 32'(flags); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL mid_reset got=%h want=%h", obs, exp_v); end
      obs = 32'(INPR); exp_v = sb.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL mid_reset_inpr got=%h want=%h", obs, exp_v); end
   endtask

   initial begin
      test_reset();
      test_input();
      test_output();
      test_out_collision();
      test_in_collision();
      test_interrupt();
      test_reset_mid();
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL scoreboard_left got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
